mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencing arbiter that shares one single-port memory between the instruction-fetch requester and the load/store unit of the RV32I core. It grants one transaction at a time, tracks the fixed memory read latency, and steers the response back to the owning requester. Data accesses have priority, but a starvation counter guarantees forward progress for fetch. It sits between the pc/fetch logic, the lsu and the shared memory macro.

## Interface
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles, legal range 1..4
- STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting, legal range 1..15
- i_clk  in  1  single clock; all state updates on the rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_if_req  in  1  fetch request
- i_if_addr  in  ADDR_W  fetch word address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  fetch read data valid, one-cycle pulse
- o_if_rdata  out  DATA_W  fetch read data
- i_ls_req  in  1  load/store request
- i_ls_wren  in  1  1 = store, 0 = load
- i_ls_addr  in  ADDR_W  load/store address
- i_ls_wdata  in  DATA_W  store data
- i_ls_bmask  in  DATA_W/8  store byte enables
- o_ls_gnt  out  1  load/store request accepted this cycle
- o_ls_rvalid  out  1  load data valid or store acknowledge, one-cycle pulse
- o_ls_rdata  out  DATA_W  load data; 0 on a store acknowledge
- o_mem_req  out  1  memory command valid
- o_mem_wren  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_bmask  out  DATA_W/8  memory byte enables; all ones for fetch and loads
- i_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the command

## Operation
- FSM states: ST_IDLE (no transaction outstanding), ST_BUSY (waiting for the response).
- A grant is issued only in ST_IDLE or in the response cycle of ST_BUSY. It is combinational from the request: the gnt pulse and o_mem_req with the muxed command are asserted in the same cycle.
- Winner selection: i_ls_req wins over i_if_req unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt: +1 (saturating) on each data grant while i_if_req is high. Cleared on a fetch grant or in any cycle with i_if_req low.
- On grant: latch owner (OWN_IF/OWN_LS) and the wren flag, load lat_cnt = MEM_LAT, go to ST_BUSY.
- In ST_BUSY, lat_cnt decrements each cycle. The response cycle is the cycle with lat_cnt == 1 after the decrement. In that cycle:
  - the owner's rvalid pulses;
  - rdata = i_mem_rdata, or 0 for a store.
- In the response cycle, a new grant is allowed (stay in ST_BUSY); otherwise return to ST_IDLE.
- Requesters hold req and all attributes stable until gnt. The arbiter does not buffer commands.
- Non-owner rvalid stays 0. Non-owner rdata stays 0.

## Timing
- Reset values: all outputs 0, state ST_IDLE, starve_cnt 0, lat_cnt 0, owner OWN_IF.
- Latency: grant at cycle t gives rvalid at cycle t+MEM_LAT.
- Throughput: one transaction per MEM_LAT cycles. With MEM_LAT = 1, back-to-back grants run every cycle.
- Simultaneous requests: exactly one gnt per cycle, never both.
- Reset asserted mid-transaction: the outstanding response is dropped, and no rvalid appears after reset is released.
- Counter widths: lat_cnt is $clog2(MEM_LAT+1) bits; starve_cnt is 4 bits, saturating at STARVE_MAX.

## Structure
- Package mem_arb_pkg contains:
  - state_t enum {ST_IDLE, ST_BUSY};
  - owner_t enum {OWN_IF, OWN_LS};
  - mem_cmd_t struct {wren, addr, wdata, bmask};
  - localparam MAX_LAT = 4.
- One sub-module: mem_arb_pick, which holds starve_cnt and produces the one-hot grant vector. Command muxing, the FSM and response steering stay in mem_arbiter.

## Test plan
- Fetch only, MEM_LAT=1, addresses 0x0/0x4/0x8 on consecutive cycles -> o_if_gnt high 3 cycles; o_if_rvalid at t+1..t+3 with the matching i_mem_rdata.
- Load at 0x100 with memory returning 0xDEADBEEF, MEM_LAT=3 -> o_ls_gnt at t; no new gnt at t+1 or t+2; o_ls_rvalid with 0xDEADBEEF at t+3.
- Store 0x12345678, bmask 4'b0011 -> o_mem_wren=1 and o_mem_bmask=4'b0011 at grant; o_ls_rvalid one cycle later with o_ls_rdata=0.
- i_if_req and i_ls_req held high, STARVE_MAX=4, MEM_LAT=1 -> grant pattern LS,LS,LS,LS,IF repeating; never two gnts in the same cycle.
- Reset asserted 1 cycle after a MEM_LAT=3 load grant -> all outputs 0 immediately; no o_ls_rvalid in the 5 cycles after release.
- Fetch at 0x40 and a load at 0x80 requested in the same cycle -> o_ls_gnt first, o_if_gnt in the load's response cycle; responses steered to the correct port.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
// Command struct widths follow the RV32I memory port.
package mem_arb_pkg;

  localparam int MAX_LAT    = 4;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  typedef struct packed {
    logic                  wren;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_MASK_W-1:0] bmask;
  } mem_cmd_t;

  // Instruction fetch is always a full-word read.
  function automatic mem_cmd_t fetch_cmd(input logic [ARB_ADDR_W-1:0] addr);
    mem_cmd_t cmd;
    cmd.wren  = 1'b0;
    cmd.addr  = addr;
    cmd.wdata = '0;
    cmd.bmask = '1;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter bundled into one interface.
// slave = arbiter side, master = requesters plus memory macro.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ls_req;
  logic                  ls_wren;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic [DATA_W/8-1:0]   ls_bmask;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_req;
  logic                  mem_wren;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_bmask;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_wren, ls_addr, ls_wdata, ls_bmask,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_wren, ls_addr, ls_wdata, ls_bmask,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store: data first, with a
// saturating starvation counter that hands the slot to fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       allow,
  input  logic       if_req,
  input  logic       ls_req,
  output logic [1:0] gnt
);

  logic [3:0] starve_cnt_reg;
  logic       fetch_turn;

  assign fetch_turn = (starve_cnt_reg == 4'(STARVE_MAX));

  always_comb begin
    gnt         = '0;
    gnt[GNT_IF] = allow & if_req & (~ls_req | fetch_turn);
    gnt[GNT_LS] = allow & ls_req & ~(if_req & fetch_turn);
  end

  // Counts data wins only while fetch is actually waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (!if_req || gnt[GNT_IF]) begin
      starve_cnt_reg <= '0;
    end else if (gnt[GNT_LS] && !fetch_turn) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store: grants one
// command at a time, waits out the read latency, steers the response back.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_arbiter_if.slave  bus
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  state_t           state_reg;
  owner_t           owner_reg;
  logic             wren_reg;
  logic [LAT_W-1:0] lat_cnt_reg;

  logic             resp;
  logic             allow;
  logic [1:0]       gnt;
  logic             launch;
  mem_cmd_t         cmd;

  assign resp   = (state_reg == ST_BUSY) && (lat_cnt_reg == LAT_W'(1));
  // Reset gates the grant so every output is quiet while i_reset is low.
  assign allow  = i_reset && ((state_reg == ST_IDLE) || resp);
  assign launch = |gnt;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .allow  (allow),
    .if_req (bus.if_req),
    .ls_req (bus.ls_req),
    .gnt    (gnt)
  );

  always_comb begin
    cmd = '0;
    if (gnt[GNT_LS]) begin
      cmd.wren  = bus.ls_wren;
      cmd.addr  = bus.ls_addr;
      cmd.wdata = bus.ls_wren ? bus.ls_wdata : '0;
      cmd.bmask = bus.ls_wren ? bus.ls_bmask : '1;
    end else if (gnt[GNT_IF]) begin
      cmd = fetch_cmd(bus.if_addr);
    end
  end

  assign bus.if_gnt    = gnt[GNT_IF];
  assign bus.ls_gnt    = gnt[GNT_LS];
  assign bus.mem_req   = launch;
  assign bus.mem_wren  = cmd.wren;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.mem_bmask = cmd.bmask;

  assign bus.if_rvalid = resp && (owner_reg == OWN_IF);
  assign bus.ls_rvalid = resp && (owner_reg == OWN_LS);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = (bus.ls_rvalid && !wren_reg) ? bus.mem_rdata : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= OWN_IF;
      wren_reg    <= 1'b0;
      lat_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            state_reg   <= ST_BUSY;
            owner_reg   <= gnt[GNT_LS] ? OWN_LS : OWN_IF;
            wren_reg    <= cmd.wren;
            lat_cnt_reg <= LAT_W'(MEM_LAT);
          end
        end
        ST_BUSY: begin
          // A grant in the response cycle overlaps the next command with it.
          if (launch) begin
            owner_reg   <= gnt[GNT_LS] ? OWN_LS : OWN_IF;
            wren_reg    <= cmd.wren;
            lat_cnt_reg <= LAT_W'(MEM_LAT);
          end else if (resp) begin
            state_reg   <= ST_IDLE;
            wren_reg    <= 1'b0;
            lat_cnt_reg <= '0;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          lat_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance
// driven through fixed vectors with hand-computed expectations.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst3_n;
  int   checks = 0;
  int   errors = 0;
  logic exp_ls;
  logic prev_ls;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .i_clk   (clk),
    .i_reset (rst1_n),
    .bus     (bus1)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .i_clk   (clk),
    .i_reset (rst3_n),
    .bus     (bus3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Enter a new cycle shortly after the rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well ahead of the next edge.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.ls_req = 0; bus1.ls_wren = 0;
    bus1.ls_addr = 0; bus1.ls_wdata = 0; bus1.ls_bmask = 0; bus1.mem_rdata = 0;
    bus3.if_req = 0; bus3.if_addr = 0; bus3.ls_req = 0; bus3.ls_wren = 0;
    bus3.ls_addr = 0; bus3.ls_wdata = 0; bus3.ls_bmask = 0; bus3.mem_rdata = 0;
    settle();
    $display("txn: reset state");
    chk("rst_if_gnt",    32'(bus1.if_gnt),    32'h0);
    chk("rst_ls_gnt",    32'(bus1.ls_gnt),    32'h0);
    chk("rst_mem_req",   32'(bus1.mem_req),   32'h0);
    chk("rst_if_rvalid", 32'(bus1.if_rvalid), 32'h0);
    chk("rst_ls_rvalid", 32'(bus3.ls_rvalid), 32'h0);
    chk("rst_mem_bmask", 32'(bus1.mem_bmask), 32'h0);
    cyc();
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    cyc();

    // Fetch burst 0x0/0x4/0x8, MEM_LAT=1.
    $display("txn: fetch 0x0");
    bus1.if_req = 1; bus1.if_addr = 32'h0;
    settle();
    chk("f0_gnt",   32'(bus1.if_gnt),    32'h1);
    chk("f0_ls",    32'(bus1.ls_gnt),    32'h0);
    chk("f0_addr",  bus1.mem_addr,       32'h0);
    chk("f0_bmask", 32'(bus1.mem_bmask), 32'hF);
    chk("f0_wren",  32'(bus1.mem_wren),  32'h0);
    chk("f0_rv",    32'(bus1.if_rvalid), 32'h0);
    cyc();
    $display("txn: fetch 0x4");
    bus1.if_addr = 32'h4; bus1.mem_rdata = 32'hA0A0_0000;
    settle();
    chk("f1_gnt",   32'(bus1.if_gnt),    32'h1);
    chk("f1_addr",  bus1.mem_addr,       32'h4);
    chk("f1_rv",    32'(bus1.if_rvalid), 32'h1);
    chk("f1_rdata", bus1.if_rdata,       32'hA0A0_0000);
    cyc();
    $display("txn: fetch 0x8");
    bus1.if_addr = 32'h8; bus1.mem_rdata = 32'hA0A0_0004;
    settle();
    chk("f2_gnt",   32'(bus1.if_gnt),    32'h1);
    chk("f2_addr",  bus1.mem_addr,       32'h8);
    chk("f2_rdata", bus1.if_rdata,       32'hA0A0_0004);
    cyc();
    bus1.if_req = 0; bus1.mem_rdata = 32'hA0A0_0008;
    settle();
    chk("f3_gnt",   32'(bus1.if_gnt),    32'h0);
    chk("f3_req",   32'(bus1.mem_req),   32'h0);
    chk("f3_rv",    32'(bus1.if_rvalid), 32'h1);
    chk("f3_rdata", bus1.if_rdata,       32'hA0A0_0008);
    chk("f3_lsrv",  32'(bus1.ls_rvalid), 32'h0);
    cyc();
    bus1.mem_rdata = 32'h0;
    settle();
    chk("f4_rv",    32'(bus1.if_rvalid), 32'h0);

    // Store on MEM_LAT=1.
    cyc();
    $display("txn: store 0x12345678 -> 0x200");
    bus1.ls_req = 1; bus1.ls_wren = 1; bus1.ls_addr = 32'h200;
    bus1.ls_wdata = 32'h1234_5678; bus1.ls_bmask = 4'b0011;
    settle();
    chk("st_gnt",   32'(bus1.ls_gnt),    32'h1);
    chk("st_wren",  32'(bus1.mem_wren),  32'h1);
    chk("st_bmask", 32'(bus1.mem_bmask), 32'h3);
    chk("st_addr",  bus1.mem_addr,       32'h200);
    chk("st_wdata", bus1.mem_wdata,      32'h1234_5678);
    cyc();
    bus1.ls_req = 0; bus1.ls_wren = 0; bus1.mem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("st_rv",    32'(bus1.ls_rvalid), 32'h1);
    chk("st_rdata", bus1.ls_rdata,       32'h0);
    chk("st_ifrv",  32'(bus1.if_rvalid), 32'h0);
    chk("st_ifrd",  bus1.if_rdata,       32'h0);

    // Both requesters held: LS,LS,LS,LS,IF repeating.
    prev_ls = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      $display("txn: contended cycle %0d", k);
      bus1.if_req = 1; bus1.if_addr = 32'h1000;
      bus1.ls_req = 1; bus1.ls_addr = 32'h2000; bus1.ls_wren = 0; bus1.ls_bmask = 4'b0;
      bus1.mem_rdata = 32'h5000 + 32'(k);
      settle();
      exp_ls = ((k % 5) != 4);
      chk("sv_ls_gnt", 32'(bus1.ls_gnt), 32'(exp_ls));
      chk("sv_if_gnt", 32'(bus1.if_gnt), 32'(!exp_ls));
      chk("sv_one_hot", 32'(bus1.if_gnt & bus1.ls_gnt), 32'h0);
      chk("sv_addr", bus1.mem_addr, exp_ls ? 32'h2000 : 32'h1000);
      if (k > 0) begin
        chk("sv_ls_rv", 32'(bus1.ls_rvalid), 32'(prev_ls));
        chk("sv_if_rv", 32'(bus1.if_rvalid), 32'(!prev_ls));
        chk("sv_ls_rd", bus1.ls_rdata, prev_ls ? 32'h5000 + 32'(k) : 32'h0);
      end
      prev_ls = exp_ls;
    end
    cyc();
    bus1.if_req = 0; bus1.ls_req = 0; bus1.mem_rdata = 32'h5555_0009;
    settle();
    chk("sv_drain_req", 32'(bus1.mem_req),   32'h0);
    chk("sv_drain_rv",  32'(bus1.if_rvalid), 32'h1);
    chk("sv_drain_rd",  bus1.if_rdata,       32'h5555_0009);

    // Load with MEM_LAT=3; a follow-up load waits for the response cycle.
    cyc();
    $display("txn: load 0x100 (lat 3)");
    bus3.ls_req = 1; bus3.ls_wren = 0; bus3.ls_addr = 32'h100; bus3.ls_bmask = 4'b0;
    settle();
    chk("ld_gnt",   32'(bus3.ls_gnt),    32'h1);
    chk("ld_addr",  bus3.mem_addr,       32'h100);
    chk("ld_wren",  32'(bus3.mem_wren),  32'h0);
    chk("ld_bmask", 32'(bus3.mem_bmask), 32'hF);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      bus3.ls_addr = 32'h104;
      settle();
      chk("ld_wait_gnt", 32'(bus3.ls_gnt),    32'h0);
      chk("ld_wait_req", 32'(bus3.mem_req),   32'h0);
      chk("ld_wait_rv",  32'(bus3.ls_rvalid), 32'h0);
    end
    cyc();
    $display("txn: load 0x104 in response cycle");
    bus3.mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("ld_rv",     32'(bus3.ls_rvalid), 32'h1);
    chk("ld_rdata",  bus3.ls_rdata,       32'hDEAD_BEEF);
    chk("ld2_gnt",   32'(bus3.ls_gnt),    32'h1);
    chk("ld2_addr",  bus3.mem_addr,       32'h104);
    cyc();
    bus3.ls_req = 0; bus3.mem_rdata = 32'h0;
    settle();
    chk("ld2_wait", 32'(bus3.ls_rvalid), 32'h0);
    cyc();
    cyc();
    bus3.mem_rdata = 32'hCAFE_F00D;
    settle();
    chk("ld2_rv",    32'(bus3.ls_rvalid), 32'h1);
    chk("ld2_rdata", bus3.ls_rdata,       32'hCAFE_F00D);

    // Simultaneous fetch 0x40 and load 0x80 on MEM_LAT=3.
    cyc();
    $display("txn: fetch 0x40 + load 0x80");
    bus3.mem_rdata = 32'h0;
    bus3.if_req = 1; bus3.if_addr = 32'h40;
    bus3.ls_req = 1; bus3.ls_addr = 32'h80;
    settle();
    chk("sim_ls_gnt", 32'(bus3.ls_gnt), 32'h1);
    chk("sim_if_gnt", 32'(bus3.if_gnt), 32'h0);
    chk("sim_addr",   bus3.mem_addr,    32'h80);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      bus3.ls_req = 0;
      settle();
      chk("sim_wait_if_gnt", 32'(bus3.if_gnt), 32'h0);
    end
    cyc();
    bus3.mem_rdata = 32'h8080_8080;
    settle();
    chk("sim_ls_rv",    32'(bus3.ls_rvalid), 32'h1);
    chk("sim_ls_rd",    bus3.ls_rdata,       32'h8080_8080);
    chk("sim_if_rv0",   32'(bus3.if_rvalid), 32'h0);
    chk("sim_if_gnt2",  32'(bus3.if_gnt),    32'h1);
    chk("sim_if_addr",  bus3.mem_addr,       32'h40);
    cyc();
    bus3.if_req = 0; bus3.mem_rdata = 32'h0;
    settle();
    chk("sim_idle_rv", 32'(bus3.if_rvalid | bus3.ls_rvalid), 32'h0);
    cyc();
    cyc();
    bus3.mem_rdata = 32'h4040_4040;
    settle();
    chk("sim_if_rv",  32'(bus3.if_rvalid), 32'h1);
    chk("sim_if_rd",  bus3.if_rdata,       32'h4040_4040);
    chk("sim_ls_rv1", 32'(bus3.ls_rvalid), 32'h0);
    chk("sim_ls_rd1", bus3.ls_rdata,       32'h0);

    // Reset one cycle after a MEM_LAT=3 load grant.
    cyc();
    $display("txn: load 0x300 then reset");
    bus3.mem_rdata = 32'h0;
    bus3.ls_req = 1; bus3.ls_addr = 32'h300;
    settle();
    chk("rl_gnt", 32'(bus3.ls_gnt), 32'h1);
    cyc();
    rst3_n = 1'b0;
    bus3.mem_rdata = 32'h3333_3333;
    settle();
    chk("rl_gnt_in_rst", 32'(bus3.ls_gnt),    32'h0);
    chk("rl_req_in_rst", 32'(bus3.mem_req),   32'h0);
    chk("rl_addr_in_rst", bus3.mem_addr,      32'h0);
    chk("rl_rv_in_rst",  32'(bus3.ls_rvalid), 32'h0);
    chk("rl_rd_in_rst",  bus3.ls_rdata,       32'h0);
    cyc();
    bus3.ls_req = 0;
    cyc();
    rst3_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rl_post_ls_rv", 32'(bus3.ls_rvalid), 32'h0);
      chk("rl_post_if_rv", 32'(bus3.if_rvalid), 32'h0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
